instr_encoder: RTL and testbench

//  Packs opcode/operand fields into 32-bit instruction words: opc in [3:0], operands in [31:4].

---
 rtl/instr_pkg.sv | 35 +++
 rtl/instr_word_fifo.sv | 64 ++++++
 rtl/instr_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_encoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pkg.sv
// Shared instruction-set definitions for the encoder and decoder: field widths,
// opcode enumeration, encoder FSM states and the opcode legality check.
package instr_pkg;

    localparam int OPC_W  = 4;
    localparam int OPR_W  = 28;
    localparam int WORD_W = 32;

    typedef enum logic [OPC_W-1:0] {
        PUSH = 4'h0,
        POP  = 4'h1,
        ADD  = 4'h2,
        SUB  = 4'h3,
        MOV  = 4'h4,
        JMP  = 4'h5,
        LODI = 4'h6,
        STOR = 4'h7,
        CALL = 4'h8,
        RET  = 4'h9,
        CMP  = 4'hA,
        NOP  = 4'hB,
        LOCK = 4'hC
    } opcode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_IMM  = 1'b1
    } enc_state_e;

    // Codes above LOCK are reserved and never reach the instruction stream.
    function automatic logic is_legal_opc(input logic [OPC_W-1:0] opc);
        return (opc <= 4'hC);
    endfunction

endpackage

// File: rtl/instr_word_fifo.sv
// Synchronous word FIFO with first-word-fall-through head; when empty the head
// keeps showing the last word popped (zero after reset).
module instr_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] last_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = empty ? last_reg : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            last_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                last_reg   <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs opcode/operand field sets into 32-bit words and streams them through a
// word FIFO; LODI is followed by a raw immediate word. Define
// INSTR_ENC_STATS_EN to add the words_emitted / illegal_count counters.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
`ifdef INSTR_ENC_STATS_EN
    ,
    parameter int STAT_W     = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  in_opc,
    input  logic [OPR_W-1:0]  in_oprands,
    input  logic [WORD_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_word,
    output logic              err_illegal,
    output logic              busy
`ifdef INSTR_ENC_STATS_EN
    ,
    output logic [STAT_W-1:0] words_emitted,
    output logic [STAT_W-1:0] illegal_count
`endif
);

    enc_state_e                   state_reg;
    enc_state_e                   state_next;
    logic [WORD_W-1:0]            imm_reg;
    logic                         err_reg;
    logic                         fifo_push;
    logic [WORD_W-1:0]            push_data;
    logic                         fifo_pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  fifo_count;
    logic                         accept;
    logic                         opc_legal;
    logic                         opc_lodi;

    assign opc_legal   = is_legal_opc(in_opc);
    assign opc_lodi    = (in_opc == LODI);
    assign accept      = in_valid && in_ready;
    assign out_valid   = !fifo_empty;
    assign fifo_pop    = out_valid && out_ready;
    assign err_illegal = err_reg;
    assign busy        = (state_reg != ST_IDLE) || (fifo_count != '0);

    instr_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (fifo_pop),
        .head      (out_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept && opc_lodi) state_next = ST_IMM;
            ST_IMM:  if (!fifo_full)         state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // While the immediate is pending the input side stays closed, so the
    // header and its immediate always sit next to each other in the FIFO.
    always_comb begin
        in_ready  = 1'b0;
        fifo_push = 1'b0;
        push_data = {in_oprands, in_opc};
        case (state_reg)
            ST_IDLE: begin
                in_ready  = !fifo_full && !rst;
                fifo_push = in_valid && !fifo_full && !rst && opc_legal;
            end
            ST_IMM: begin
                fifo_push = !fifo_full;
                push_data = imm_reg;
            end
            default: begin
                in_ready  = 1'b0;
                fifo_push = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imm_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (accept && opc_lodi) begin
                imm_reg <= in_imm;
            end
            err_reg <= accept && !opc_legal;
        end
    end

`ifdef INSTR_ENC_STATS_EN
    logic [STAT_W-1:0] words_reg;
    logic [STAT_W-1:0] illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            words_reg   <= '0;
            illegal_reg <= '0;
        end else begin
            if (fifo_pop && (words_reg != '1)) begin
                words_reg <= words_reg + 1'b1;
            end
            if (err_reg && (illegal_reg != '1)) begin
                illegal_reg <= illegal_reg + 1'b1;
            end
        end
    end

    assign words_emitted = words_reg;
    assign illegal_count = illegal_reg;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder; a queue-based model of the
// expected word stream predicts every output once per cycle.
module tb_instr_encoder;

    localparam int DEPTH = 4;
`ifdef INSTR_ENC_STATS_EN
    localparam int SW = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opc;
    logic [27:0] in_oprands;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic        err_illegal;
    logic        busy;
`ifdef INSTR_ENC_STATS_EN
    logic [SW-1:0] words_emitted;
    logic [SW-1:0] illegal_count;
`endif

    always #5 clk = ~clk;

    instr_encoder #(
        .FIFO_DEPTH (DEPTH)
`ifdef INSTR_ENC_STATS_EN
        ,
        .STAT_W     (SW)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_opc      (in_opc),
        .in_oprands  (in_oprands),
        .in_imm      (in_imm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .err_illegal (err_illegal),
        .busy        (busy)
`ifdef INSTR_ENC_STATS_EN
        ,
        .words_emitted (words_emitted),
        .illegal_count (illegal_count)
`endif
    );

    // Model: q holds every word still owed to the consumer, in order; occ counts
    // those physically buffered (a pending immediate is the last entry of q).
    logic [31:0] q[$];
    int          occ;
    bit          pending;
    logic [31:0] last_word;
    bit          exp_err;
    int          em_cnt;
    int          il_cnt;
    bit          last_acc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit exp_rdy;
        bit acc;
        bit pop;
        bit lands;
        @(negedge clk);
        if (rst) begin
            chk("in_ready_rst", 32'(in_ready), 32'd0);
            q.delete();
            occ = 0; pending = 0; last_word = '0; exp_err = 0;
            em_cnt = 0; il_cnt = 0; last_acc = 0;
        end else begin
            exp_rdy = !pending && (occ < DEPTH);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(occ > 0));
            chk("out_word", out_word, (occ > 0) ? q[0] : last_word);
            chk("err_illegal", 32'(err_illegal), 32'(exp_err));
            chk("busy", 32'(busy), 32'(pending || (occ > 0)));
`ifdef INSTR_ENC_STATS_EN
            chk("words_emitted", 32'(words_emitted), 32'(em_cnt));
            chk("illegal_count", 32'(illegal_count), 32'(il_cnt));
`endif
            acc   = in_valid && exp_rdy;
            pop   = (occ > 0) && out_ready;
            lands = pending && (occ < DEPTH);
            if (exp_err && il_cnt < 32'hFFFF) il_cnt++;
            if (pop) begin
                last_word = q.pop_front();
                occ--;
                if (em_cnt < 32'hFFFF) em_cnt++;
            end
            if (lands) begin
                pending = 0;
                occ++;
            end
            exp_err = acc && (in_opc > 4'hC);
            if (acc && in_opc <= 4'hC) begin
                q.push_back({in_oprands, in_opc});
                occ++;
                if (in_opc == 4'h6) begin
                    q.push_back(in_imm);
                    pending = 1;
                end
            end
            last_acc = acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] opc, input logic [27:0] opr, input logic [31:0] imm);
        in_valid = 1'b1; in_opc = opc; in_oprands = opr; in_imm = imm;
        last_acc = 0;
        for (int i = 0; i < 40 && !last_acc; i++) step();
        chk("accept_timeout", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        $display("send opc=%h opr=%h imm=%h accepted=%0d", opc, opr, imm, last_acc);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 40 && (occ > 0 || pending); i++) step();
        chk("drain_timeout", 32'(occ), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_opc = '0; in_oprands = '0; in_imm = '0;
        out_ready = 1'b0;
        do_reset();

        // Post-reset idle outputs
        step();
        chk("reset_word", out_word, 32'h0);

        // 1: single MOV word appears one cycle after accept
        out_ready = 1'b1;
        send(4'h4, 28'h0000123, 32'h0);
        chk("t1_word", out_word, 32'h00001234);
        step();

        // 2: LODI header then immediate, input closed while immediate pending
        send(4'h6, 28'h0000001, 32'hDEADBEEF);
        chk("t2_header", out_word, 32'h00000016);
        chk("t2_imm_ready", 32'(in_ready), 32'd0);
        step();
        chk("t2_imm", out_word, 32'hDEADBEEF);
        step();

        // 3: illegal opcode dropped with a single error pulse
        send(4'hE, 28'h1234567, 32'h0);
        chk("t3_err", 32'(err_illegal), 32'd1);
        chk("t3_no_word", 32'(out_valid), 32'd0);
        step();
        chk("t3_err_clr", 32'(err_illegal), 32'd0);
`ifdef INSTR_ENC_STATS_EN
        chk("t3_illegal_count", 32'(illegal_count), 32'd1);
`endif

        // 4: five MOVs against a stalled consumer
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(4'h4, 28'(i + 1), 32'h0);
        in_valid = 1'b1; in_opc = 4'h4; in_oprands = 28'd5;
        repeat (3) step();
        chk("t4_full_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 40 && !last_acc; i++) step();
        chk("t4_fifth_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        drain();

        // 5: LODI header fills the FIFO, immediate waits for one pop
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(4'h2, 28'(16 + i), 32'h0);
        send(4'h6, 28'h00000AB, 32'h12345678);
        repeat (2) step();
        chk("t5_wait_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        chk("t5_imm_written", 32'(out_valid), 32'd1);
        drain();

        // 6: reset while an immediate is pending with two words queued
        out_ready = 1'b0;
        send(4'h4, 28'h0000077, 32'h0);
        send(4'h6, 28'h0000088, 32'hCAFEF00D);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        step();

        // Randomized traffic with a random consumer
        for (int i = 0; i < 400; i++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_opc     = ($urandom_range(0, 5) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
            in_oprands = 28'($urandom);
            in_imm     = $urandom;
            out_ready  = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 1'b0;
        drain();
        $display("random phase done, words_left=%0d", occ);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
